// File: rtl/dm_bus_bridge.sv
// MEM-stage data bus bridge: posts stores through a one-entry write buffer and
// stalls loads until the full word returns over a single-outstanding valid/ready bus.
module dm_bus_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_byteen,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_rd,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_byteen,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_rvalid
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              wb_full_q, wb_full_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [3:0]        wb_be_q, wb_be_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;

  logic              is_store;
  logic              handshake;
  logic [ADDR_W-1:0] word_addr;

  // A load with nonzero byte enables is treated purely as a load.
  assign is_store  = (cpu_byteen != 4'b0000) && !cpu_rd;
  assign handshake = bus_valid_q && bus_ready;
  assign word_addr = cpu_addr & ~ADDR_W'(3);

  assign stall = !reset && ((is_store && wb_full_q) || (cpu_rd && state_q != RESP));

  always_comb begin
    state_d     = state_q;
    wb_full_d   = wb_full_q;
    wb_addr_d   = wb_addr_q;
    wb_be_d     = wb_be_q;
    wb_data_d   = wb_data_q;
    rdata_d     = rdata_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;

    if (wb_full_q && handshake && bus_we_q) begin
      wb_full_d = 1'b0;
    end
    if (is_store && !wb_full_q) begin
      wb_full_d = 1'b1;
      wb_addr_d = word_addr;
      wb_be_d   = cpu_byteen;
      wb_data_d = cpu_wdata;
    end

    case (state_q)
      IDLE:    if (cpu_rd && !wb_full_q) state_d = RD_REQ;
      RD_REQ:  if (handshake) state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus registers are loaded from next-state so requests appear one cycle after the decision.
    if (bus_valid_q && !bus_ready) begin
      bus_valid_d = 1'b1;
    end else if (state_d == RD_REQ) begin
      bus_valid_d = 1'b1;
      bus_we_d    = 1'b0;
      bus_addr_d  = word_addr;
      bus_be_d    = 4'b1111;
    end else if (wb_full_d && state_d == IDLE) begin
      bus_valid_d = 1'b1;
      bus_we_d    = 1'b1;
      bus_addr_d  = wb_addr_d;
      bus_be_d    = wb_be_d;
      bus_wdata_d = wb_data_d;
    end else begin
      bus_valid_d = 1'b0;
      bus_we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wb_full_q   <= 1'b0;
      wb_addr_q   <= '0;
      wb_be_q     <= '0;
      wb_data_q   <= '0;
      rdata_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_full_q   <= wb_full_d;
      wb_addr_q   <= wb_addr_d;
      wb_be_q     <= wb_be_d;
      wb_data_q   <= wb_data_d;
      rdata_q     <= rdata_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign bus_valid  = bus_valid_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_byteen = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule
